dbg_reg_access: RTL

Debug-side sequencer that feeds the register file's JTAG port (jtag_we/jtag_addr/jtag_data) and consumes its jtag read data. It accepts one register read/write command at a time from the debug transport module and halts the core before touching the register file, because the register file gives EX writes priority over JTAG writes. It performs the access, then returns a response with data and an error flag.

---
 rtl/dbg_reg_access.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dbg_reg_access.sv
// Debug register-access sequencer: halts the core, then performs one JTAG read or write to the register file and returns a response.
// Optional build macro DBG_WR_VERIFY_EN adds a read-back VERIFY cycle after each write.
module dbg_reg_access #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int HALT_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  output logic              halt_req_o,
  input  logic              halted_i,
  output logic              jtag_we_o,
  output logic [ADDR_W-1:0] jtag_addr_o,
  output logic [DATA_W-1:0] jtag_data_o,
  input  logic [DATA_W-1:0] jtag_rdata_i
);

  localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3
`ifdef DBG_WR_VERIFY_EN
    ,VERIFY = 3'd4
`endif
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cmd_we;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_data;

  // All outputs are registered and set for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      cmd_we       <= 1'b0;
      cmd_addr     <= '0;
      cmd_data     <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_err_o   <= 1'b0;
      halt_req_o   <= 1'b0;
      jtag_we_o    <= 1'b0;
      jtag_addr_o  <= '0;
      jtag_data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            cmd_we      <= req_we_i;
            cmd_addr    <= req_addr_i;
            cmd_data    <= req_data_i;
            cnt         <= '0;
            state       <= HALT;
            req_ready_o <= 1'b0;
            halt_req_o  <= 1'b1;
            jtag_addr_o <= req_addr_i;
          end
        end
        HALT: begin
          if (halted_i) begin
            if (cmd_we && (cmd_addr == '0)) begin
              // x0 is hardwired; reject the write without touching the register file.
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_data_o  <= '0;
            end else begin
              state       <= ACCESS;
              jtag_we_o   <= cmd_we;
              jtag_data_o <= cmd_we ? cmd_data : '0;
            end
          end else if (cnt == CNT_LAST) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b1;
            resp_data_o  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACCESS: begin
          jtag_we_o   <= 1'b0;
          jtag_data_o <= '0;
          resp_err_o  <= 1'b0;
          if (cmd_we) begin
            resp_data_o <= cmd_data;
`ifdef DBG_WR_VERIFY_EN
            state <= VERIFY;
`else
            state        <= RESP;
            resp_valid_o <= 1'b1;
`endif
          end else begin
            resp_data_o  <= jtag_rdata_i;
            state        <= RESP;
            resp_valid_o <= 1'b1;
          end
        end
`ifdef DBG_WR_VERIFY_EN
        VERIFY: begin
          // A concurrent EX write wins in the register file; report what actually landed.
          state        <= RESP;
          resp_valid_o <= 1'b1;
          if (jtag_rdata_i != cmd_data) begin
            resp_err_o  <= 1'b1;
            resp_data_o <= jtag_rdata_i;
          end else begin
            resp_err_o  <= 1'b0;
            resp_data_o <= cmd_data;
          end
        end
`endif
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_err_o   <= 1'b0;
            halt_req_o   <= 1'b0;
            req_ready_o  <= 1'b1;
            jtag_addr_o  <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          req_ready_o  <= 1'b1;
          resp_valid_o <= 1'b0;
          halt_req_o   <= 1'b0;
          jtag_we_o    <= 1'b0;
          jtag_addr_o  <= '0;
          jtag_data_o  <= '0;
        end
      endcase
    end
  end

endmodule
